// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - queued, lane-aligning store path onto an AHB-Lite write port
//
// Lane-aligns byte/half/word/dword stores into XLEN-wide beats with byte
// strobes, buffers them in a DEPTH-entry FIFO and issues pipelined AHB-Lite
// NONSEQ write transfers from the head of the queue.
//
// Build option: STORE_MISALIGN_TRAP_EN
//   defined   - misaligned stores are rejected and flagged on misaligned_out
//   undefined - misaligned_out is 0; the lane offset is forced down to the
//               nearest multiple of the access size and the store is queued
//
// Ports:
//   clk_in, rst_in       clock, asynchronous active-high reset
//   funct3_in[1:0]       store size (00 B, 01 H, 10 W, 11 D); bit 2 ignored
//   iadder_in            effective store address
//   rs2_in               store data, right-justified
//   mem_wr_req_in        store request from execute
//   ahb_ready_in         HREADY
//   full_out             queue full, execute must stall
//   empty_out            queue empty and bus idle (FENCE)
//   misaligned_out       current request rejected as misaligned
//   ahb_haddr_out        HADDR, beat aligned
//   ahb_hwdata_out       HWDATA
//   wr_mask_out          byte-lane strobe of the current data phase
//   ahb_hsize_out        HSIZE
//   ahb_hwrite_out       HWRITE
//   ahb_htrans_out       HTRANS (00 IDLE, 10 NONSEQ)

module store_buffer_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   iadder_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic              mem_wr_req_in,
    input  logic              ahb_ready_in,
    output logic              full_out,
    output logic              empty_out,
    output logic              misaligned_out,
    output logic [XLEN-1:0]   ahb_haddr_out,
    output logic [XLEN-1:0]   ahb_hwdata_out,
    output logic [XLEN/8-1:0] wr_mask_out,
    output logic [2:0]        ahb_hsize_out,
    output logic              ahb_hwrite_out,
    output logic [1:0]        ahb_htrans_out
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request decode and lane alignment
    // ------------------------------------------------------------------
    logic [1:0]       w_size;
    logic [3:0]       w_nbytes;
    logic [OFFW-1:0]  w_off_raw;
    logic [OFFW-1:0]  w_off_mask;
    logic [OFFW-1:0]  w_off;
    logic [LANES-1:0] w_strb_base;
    logic [LANES-1:0] w_strb;
    logic [XLEN-1:0]  w_dmask;
    logic [XLEN-1:0]  w_data;
    logic [XLEN-1:0]  w_addr;
    logic             w_accept_ok;
    logic             w_unused;

    assign w_unused = funct3_in[2];

    always_comb begin
        w_size = funct3_in[1:0];
        // A 32-bit build has no doubleword lane pattern; fall back to word.
        if (XLEN == 32 && w_size == 2'b11) begin
            w_size = 2'b10;
        end
    end

    assign w_nbytes   = 4'd1 << w_size;
    assign w_off_raw  = iadder_in[OFFW-1:0];
    assign w_off_mask = OFFW'(w_nbytes - 4'd1);

`ifdef STORE_MISALIGN_TRAP_EN
    logic w_aligned;
    assign w_aligned      = (w_off_raw & w_off_mask) == '0;
    assign w_off          = w_off_raw;
    assign w_accept_ok    = w_aligned;
    assign misaligned_out = mem_wr_req_in && !w_aligned;
`else
    // Legacy behaviour: round the offset down to the access size.
    assign w_off          = w_off_raw & ~w_off_mask;
    assign w_accept_ok    = 1'b1;
    assign misaligned_out = 1'b0;
`endif

    always_comb begin
        w_strb_base = '0;
        w_dmask     = '0;
        for (int i = 0; i < LANES; i++) begin
            w_strb_base[i]    = (i < int'(w_nbytes));
            w_dmask[8*i +: 8] = {8{w_strb_base[i]}};
        end
    end

    assign w_strb = w_strb_base << w_off;
    assign w_data = (rs2_in & w_dmask) << {w_off, 3'b000};
    assign w_addr = {iadder_in[XLEN-1:OFFW], {OFFW{1'b0}}};

    // ------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_aptr;
    logic [PW-1:0]    r_dptr;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_htrans;
    logic [XLEN-1:0]  r_haddr;
    logic [XLEN-1:0]  r_hwdata;
    logic [LANES-1:0] r_mask;
    logic [2:0]       r_hsize;

    logic [XLEN-1:0]  r_q_addr [DEPTH];
    logic [XLEN-1:0]  r_q_data [DEPTH];
    logic [LANES-1:0] r_q_strb [DEPTH];
    logic [1:0]       r_q_size [DEPTH];

    logic             w_retire;
    logic             w_enq;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_a1;
    logic [XLEN-1:0]  w_a0_addr;
    logic [1:0]       w_a0_size;
    logic [XLEN-1:0]  w_a1_addr;
    logic [1:0]       w_a1_size;

    assign w_retire    = (r_state == S_DATA) && ahb_ready_in;
    // A full queue still accepts when the head retires on the same edge.
    assign w_enq       = mem_wr_req_in && w_accept_ok &&
                         ((r_count != CW'(DEPTH)) || w_retire);
    assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_retire);
    assign w_a1        = r_aptr + PW'(1);

    // Address-phase lookups forward the entry being written this edge so a
    // store reaches the bus one cycle after it is accepted.
    always_comb begin
        w_a0_addr = r_q_addr[r_aptr];
        w_a0_size = r_q_size[r_aptr];
        w_a1_addr = r_q_addr[w_a1];
        w_a1_size = r_q_size[w_a1];
        if (w_enq && (r_wptr == r_aptr)) begin
            w_a0_addr = w_addr;
            w_a0_size = w_size;
        end
        if (w_enq && (r_wptr == w_a1)) begin
            w_a1_addr = w_addr;
            w_a1_size = w_size;
        end
    end

    // Entry storage needs no reset: validity is carried by the pointers.
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_q_addr[r_wptr] <= w_addr;
            r_q_data[r_wptr] <= w_data;
            r_q_strb[r_wptr] <= w_strb;
            r_q_size[r_wptr] <= w_size;
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM with registered AHB outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_wptr   <= '0;
            r_aptr   <= '0;
            r_dptr   <= '0;
            r_count  <= '0;
            r_htrans <= HTRANS_IDLE;
            r_haddr  <= '0;
            r_hwdata <= '0;
            r_mask   <= '0;
            r_hsize  <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_enq);
            r_count <= w_count_nxt;

            case (r_state)
                S_IDLE: begin
                    if (w_count_nxt != '0) begin
                        r_state  <= S_ADDR;
                        r_htrans <= HTRANS_NONSEQ;
                        r_haddr  <= w_a0_addr;
                        r_hsize  <= {1'b0, w_a0_size};
                    end
                end

                S_ADDR: begin
                    if (ahb_ready_in) begin
                        r_state  <= S_DATA;
                        r_aptr   <= w_a1;
                        r_hwdata <= r_q_data[r_aptr];
                        r_mask   <= r_q_strb[r_aptr];
                        // Anything beyond the entry now in data phase is
                        // presented as an overlapped address phase.
                        if (w_count_nxt > CW'(1)) begin
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= w_a1_addr;
                            r_hsize  <= {1'b0, w_a1_size};
                        end else begin
                            r_htrans <= HTRANS_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (ahb_ready_in) begin
                        r_dptr <= r_dptr + PW'(1);
                        if (r_htrans == HTRANS_NONSEQ) begin
                            // Overlapped entry moves into its data phase.
                            r_aptr   <= w_a1;
                            r_hwdata <= r_q_data[r_aptr];
                            r_mask   <= r_q_strb[r_aptr];
                            if (w_count_nxt > CW'(1)) begin
                                r_htrans <= HTRANS_NONSEQ;
                                r_haddr  <= w_a1_addr;
                                r_hsize  <= {1'b0, w_a1_size};
                            end else begin
                                r_htrans <= HTRANS_IDLE;
                            end
                        end else begin
                            r_mask <= '0;
                            // Entries that arrived during the wait were not
                            // overlapped; start a fresh address phase.
                            if (w_count_nxt != '0) begin
                                r_state  <= S_ADDR;
                                r_htrans <= HTRANS_NONSEQ;
                                r_haddr  <= w_a0_addr;
                                r_hsize  <= {1'b0, w_a0_size};
                            end else begin
                                r_state  <= S_IDLE;
                                r_htrans <= HTRANS_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_htrans <= HTRANS_IDLE;
                    r_mask   <= '0;
                end
            endcase
        end
    end

    assign full_out       = (r_count == CW'(DEPTH));
    assign empty_out      = (r_count == '0) && (r_state == S_IDLE);
    assign ahb_htrans_out = r_htrans;
    assign ahb_hwrite_out = (r_htrans == HTRANS_NONSEQ);
    assign ahb_haddr_out  = r_haddr;
    assign ahb_hwdata_out = r_hwdata;
    assign wr_mask_out    = r_mask;
    assign ahb_hsize_out  = r_hsize;

endmodule

// File: tb/tb_store_buffer_unit.sv
// tb/tb_store_buffer_unit.sv - directed self-checking bench for store_buffer_unit

module tb_store_buffer_unit;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 32-bit, DEPTH=4 instance
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        req;
    logic        full, empty, mis;
    logic [31:0] haddr, hwdata;
    logic [3:0]  mask;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [1:0]  htrans;

    // 64-bit, DEPTH=2 instance
    logic [2:0]  f3_64;
    logic [63:0] addr_64;
    logic [63:0] rs2_64;
    logic        req_64;
    logic        full_64, empty_64, mis_64;
    logic [63:0] haddr_64, hwdata_64;
    logic [7:0]  mask_64;
    logic [2:0]  hsize_64;
    logic        hwrite_64;
    logic [1:0]  htrans_64;

    store_buffer_unit #(.XLEN(32), .DEPTH(4)) u_dut32 (
        .clk_in         (clk),
        .rst_in         (rst),
        .funct3_in      (f3),
        .iadder_in      (addr),
        .rs2_in         (rs2),
        .mem_wr_req_in  (req),
        .ahb_ready_in   (rdy),
        .full_out       (full),
        .empty_out      (empty),
        .misaligned_out (mis),
        .ahb_haddr_out  (haddr),
        .ahb_hwdata_out (hwdata),
        .wr_mask_out    (mask),
        .ahb_hsize_out  (hsize),
        .ahb_hwrite_out (hwrite),
        .ahb_htrans_out (htrans)
    );

    store_buffer_unit #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk_in         (clk),
        .rst_in         (rst),
        .funct3_in      (f3_64),
        .iadder_in      (addr_64),
        .rs2_in         (rs2_64),
        .mem_wr_req_in  (req_64),
        .ahb_ready_in   (rdy),
        .full_out       (full_64),
        .empty_out      (empty_64),
        .misaligned_out (mis_64),
        .ahb_haddr_out  (haddr_64),
        .ahb_hwdata_out (hwdata_64),
        .wr_mask_out    (mask_64),
        .ahb_hsize_out  (hsize_64),
        .ahb_hwrite_out (hwrite_64),
        .ahb_htrans_out (htrans_64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        req  = 1'b1;
        f3   = f;
        addr = a;
        rs2  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (htrans !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %b want 00", htrans); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0 || mis !== 1'b0) begin n_fail++; $display("FAIL reset_flags got e=%b f=%b m=%b want 1 0 0", empty, full, mis); end
        n_tests++; if (haddr !== 32'h0 || hwdata !== 32'h0 || mask !== 4'h0 || hsize !== 3'b000 || hwrite !== 1'b0) begin n_fail++; $display("FAIL reset_bus got a=%h d=%h m=%b s=%b w=%b want zeros", haddr, hwdata, mask, hsize, hwrite); end
        n_tests++; if (empty_64 !== 1'b1 || htrans_64 !== 2'b00) begin n_fail++; $display("FAIL reset_64 got e=%b t=%b want 1 00", empty_64, htrans_64); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sb();
        rdy = 1'b1;
        drive(3'b000, 32'h0000_1003, 32'h1122_3344);
        tick();
        req = 1'b0;
        n_tests++; if (htrans !== 2'b10 || hwrite !== 1'b1) begin n_fail++; $display("FAIL sb_nonseq got t=%b w=%b want 10 1", htrans, hwrite); end
        n_tests++; if (haddr !== 32'h0000_1000 || hsize !== 3'b000) begin n_fail++; $display("FAIL sb_addr got a=%h s=%b want 00001000 000", haddr, hsize); end
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL sb_not_empty got %b want 0", empty); end
        tick();
        n_tests++; if (hwdata !== 32'h4400_0000 || mask !== 4'b1000) begin n_fail++; $display("FAIL sb_data got d=%h m=%b want 44000000 1000", hwdata, mask); end
        n_tests++; if (htrans !== 2'b00 || hwrite !== 1'b0) begin n_fail++; $display("FAIL sb_no_more got t=%b w=%b want 00 0", htrans, hwrite); end
        tick();
        n_tests++; if (empty !== 1'b1 || mask !== 4'h0) begin n_fail++; $display("FAIL sb_done got e=%b m=%b want 1 0000", empty, mask); end
    endtask

    task automatic test_sh();
        rdy = 1'b1;
        drive(3'b001, 32'h0000_2002, 32'hAABB_CCDD);
        tick();
        req = 1'b0;
        n_tests++; if (haddr !== 32'h0000_2000 || hsize !== 3'b001 || htrans !== 2'b10) begin n_fail++; $display("FAIL sh_addr got a=%h s=%b t=%b want 00002000 001 10", haddr, hsize, htrans); end
        tick();
        n_tests++; if (hwdata !== 32'hCCDD_0000 || mask !== 4'b1100) begin n_fail++; $display("FAIL sh_data got d=%h m=%b want ccdd0000 1100", hwdata, mask); end
        tick();
    endtask

    task automatic test_illegal_size();
        // size 11 on a 32-bit build behaves as a word; funct3[2] is ignored
        rdy = 1'b1;
        drive(3'b111, 32'h0000_0300, 32'hCAFE_F00D);
        tick();
        req = 1'b0;
        n_tests++; if (hsize !== 3'b010 || haddr !== 32'h0000_0300) begin n_fail++; $display("FAIL dw32_addr got s=%b a=%h want 010 00000300", hsize, haddr); end
        tick();
        n_tests++; if (hwdata !== 32'hCAFE_F00D || mask !== 4'b1111) begin n_fail++; $display("FAIL dw32_data got d=%h m=%b want cafef00d 1111", hwdata, mask); end
        tick();
    endtask

    task automatic test_misaligned();
        rdy = 1'b1;
        drive(3'b010, 32'h0000_2002, 32'h5566_7788);
        #1;
`ifdef STORE_MISALIGN_TRAP_EN
        n_tests++; if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", mis); end
        tick();
        req = 1'b0;
        n_tests++; if (htrans !== 2'b00 || empty !== 1'b1) begin n_fail++; $display("FAIL mis_rejected got t=%b e=%b want 00 1", htrans, empty); end
        tick();
        n_tests++; if (htrans !== 2'b00 || mask !== 4'h0) begin n_fail++; $display("FAIL mis_no_xfer got t=%b m=%b want 00 0000", htrans, mask); end
`else
        n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag got %b want 0", mis); end
        tick();
        drive(3'b001, 32'h0000_2003, 32'hAABB_CCDD);
        n_tests++; if (htrans !== 2'b10 || haddr !== 32'h0000_2000 || hsize !== 3'b010) begin n_fail++; $display("FAIL mis_sw_addr got t=%b a=%h s=%b want 10 00002000 010", htrans, haddr, hsize); end
        tick();
        req = 1'b0;
        n_tests++; if (hwdata !== 32'h5566_7788 || mask !== 4'b1111) begin n_fail++; $display("FAIL mis_sw_data got d=%h m=%b want 55667788 1111", hwdata, mask); end
        n_tests++; if (htrans !== 2'b10 || haddr !== 32'h0000_2000 || hsize !== 3'b001) begin n_fail++; $display("FAIL mis_sh_addr got t=%b a=%h s=%b want 10 00002000 001", htrans, haddr, hsize); end
        tick();
        n_tests++; if (hwdata !== 32'hCCDD_0000 || mask !== 4'b1100) begin n_fail++; $display("FAIL mis_sh_data got d=%h m=%b want ccdd0000 1100", hwdata, mask); end
        tick();
`endif
    endtask

    task automatic test_xlen64();
        rdy    = 1'b1;
        req_64 = 1'b1; f3_64 = 3'b011; addr_64 = 64'h8; rs2_64 = 64'h0123_4567_89AB_CDEF;
        tick();
        f3_64 = 3'b000; addr_64 = 64'hD; rs2_64 = 64'h0000_0000_0000_00EF;
        n_tests++; if (htrans_64 !== 2'b10 || haddr_64 !== 64'h8 || hsize_64 !== 3'b011) begin n_fail++; $display("FAIL sd_addr got t=%b a=%h s=%b want 10 8 011", htrans_64, haddr_64, hsize_64); end
        tick();
        req_64 = 1'b0;
        n_tests++; if (hwdata_64 !== 64'h0123_4567_89AB_CDEF || mask_64 !== 8'hFF) begin n_fail++; $display("FAIL sd_data got d=%h m=%h want 0123456789abcdef ff", hwdata_64, mask_64); end
        n_tests++; if (htrans_64 !== 2'b10 || haddr_64 !== 64'h8 || hsize_64 !== 3'b000) begin n_fail++; $display("FAIL sb64_addr got t=%b a=%h s=%b want 10 8 000", htrans_64, haddr_64, hsize_64); end
        tick();
        n_tests++; if (hwdata_64 !== 64'h0000_EF00_0000_0000 || mask_64 !== 8'h20) begin n_fail++; $display("FAIL sb64_data got d=%h m=%h want 0000ef0000000000 20", hwdata_64, mask_64); end
        tick();
        n_tests++; if (empty_64 !== 1'b1) begin n_fail++; $display("FAIL x64_empty got %b want 1", empty_64); end
    endtask

    task automatic test_full_stall();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'b010, 32'h100 + 32'(4 * i), 32'hD000_0000 + 32'(i));
            tick();
        end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after4 got %b want 1", full); end
        n_tests++; if (htrans !== 2'b10 || haddr !== 32'h100) begin n_fail++; $display("FAIL full_addr_held got t=%b a=%h want 10 00000100", htrans, haddr); end
        drive(3'b010, 32'h110, 32'hD000_0004);
        tick();
        n_tests++; if (full !== 1'b1 || haddr !== 32'h100 || mask !== 4'h0) begin n_fail++; $display("FAIL full_stall5 got f=%b a=%h m=%b want 1 00000100 0000", full, haddr, mask); end
        rdy = 1'b1;
        tick();
        n_tests++; if (hwdata !== 32'hD000_0000 || mask !== 4'hF || haddr !== 32'h104 || htrans !== 2'b10) begin n_fail++; $display("FAIL drain0 got d=%h m=%b a=%h t=%b want d0000000 1111 00000104 10", hwdata, mask, haddr, htrans); end
        rdy = 1'b0;
        tick();
        n_tests++; if (hwdata !== 32'hD000_0000 || mask !== 4'hF || haddr !== 32'h104) begin n_fail++; $display("FAIL wait_hold got d=%h m=%b a=%h want d0000000 1111 00000104", hwdata, mask, haddr); end
        rdy = 1'b1;
        tick();
        req = 1'b0;
        n_tests++; if (full !== 1'b1 || hwdata !== 32'hD000_0001 || haddr !== 32'h108) begin n_fail++; $display("FAIL same_edge got f=%b d=%h a=%h want 1 d0000001 00000108", full, hwdata, haddr); end
        tick();
        n_tests++; if (full !== 1'b0 || hwdata !== 32'hD000_0002 || haddr !== 32'h10C) begin n_fail++; $display("FAIL drain2 got f=%b d=%h a=%h want 0 d0000002 0000010c", full, hwdata, haddr); end
        tick();
        n_tests++; if (hwdata !== 32'hD000_0003 || haddr !== 32'h110 || htrans !== 2'b10) begin n_fail++; $display("FAIL drain3 got d=%h a=%h t=%b want d0000003 00000110 10", hwdata, haddr, htrans); end
        tick();
        n_tests++; if (hwdata !== 32'hD000_0004 || mask !== 4'hF || htrans !== 2'b00) begin n_fail++; $display("FAIL drain4 got d=%h m=%b t=%b want d0000004 1111 00", hwdata, mask, htrans); end
        tick();
        n_tests++; if (empty !== 1'b1 || mask !== 4'h0) begin n_fail++; $display("FAIL drain_done got e=%b m=%b want 1 0000", empty, mask); end
    endtask

    task automatic test_back_to_back();
        rdy = 1'b1;
        drive(3'b010, 32'h200, 32'hA0A0_A0A0);
        tick();
        drive(3'b010, 32'h204, 32'hB1B1_B1B1);
        n_tests++; if (htrans !== 2'b10 || haddr !== 32'h200) begin n_fail++; $display("FAIL b2b_a_addr got t=%b a=%h want 10 00000200", htrans, haddr); end
        tick();
        drive(3'b010, 32'h208, 32'hC2C2_C2C2);
        n_tests++; if (hwdata !== 32'hA0A0_A0A0 || haddr !== 32'h204 || htrans !== 2'b10) begin n_fail++; $display("FAIL b2b_1 got d=%h a=%h t=%b want a0a0a0a0 00000204 10", hwdata, haddr, htrans); end
        tick();
        req = 1'b0;
        n_tests++; if (hwdata !== 32'hB1B1_B1B1 || haddr !== 32'h208 || htrans !== 2'b10) begin n_fail++; $display("FAIL b2b_2 got d=%h a=%h t=%b want b1b1b1b1 00000208 10", hwdata, haddr, htrans); end
        tick();
        n_tests++; if (hwdata !== 32'hC2C2_C2C2 || htrans !== 2'b00 || mask !== 4'hF) begin n_fail++; $display("FAIL b2b_3 got d=%h t=%b m=%b want c2c2c2c2 00 1111", hwdata, htrans, mask); end
        tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b010, 32'h400 + 32'(4 * i), 32'hE000_0000 + 32'(i));
            tick();
        end
        req = 1'b0;
        rdy = 1'b1;
        tick();
        n_tests++; if (mask !== 4'hF || hwdata !== 32'hE000_0000) begin n_fail++; $display("FAIL rstmid_pre got m=%b d=%h want 1111 e0000000", mask, hwdata); end
        rdy = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++; if (htrans !== 2'b00 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rstmid_now got t=%b e=%b f=%b want 00 1 0", htrans, empty, full); end
        n_tests++; if (mask !== 4'h0 || haddr !== 32'h0 || hwdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus got m=%b a=%h d=%h want 0 0 0", mask, haddr, hwdata); end
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (htrans !== 2'b00 || empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_after%0d got t=%b e=%b want 00 1", i, htrans, empty); end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        req = 1'b0; f3 = 3'b000; addr = '0; rs2 = '0;
        req_64 = 1'b0; f3_64 = 3'b000; addr_64 = '0; rs2_64 = '0;
        test_reset();
        test_sb();
        test_sh();
        test_illegal_size();
        test_misaligned();
        test_xlen64();
        test_full_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer_unit.md
# store_buffer_unit

Parametrised store path between the execute stage and the AHB-Lite data bus, generalised from the single-word, combinational store unit. It lane-aligns byte, halfword, word and, for 64-bit builds, doubleword stores to `XLEN` and generates write strobes. Stores are queued in a `DEPTH`-entry FIFO so the pipeline does not stall on bus wait states. A small FSM drives pipelined AHB-Lite write transfers from the head of the queue.

## Interface
- `XLEN`, 32, data/address width; 32 or 64.
- `DEPTH`, 4, store-queue entries; power of two, at least 2.
- `clk_in`  in  1  single clock; all state updates on the rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `funct3_in`  in  3  store size in bits [1:0]: 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only). Bit 2 is ignored.
- `iadder_in`  in  XLEN  effective store address.
- `rs2_in`  in  XLEN  store data, right-justified.
- `mem_wr_req_in`  in  1  store request from execute.
- `ahb_ready_in`  in  1  AHB HREADY.
- `full_out`  out  1  queue cannot accept a store this cycle; pipeline must stall.
- `empty_out`  out  1  queue empty and no transfer in flight; used by FENCE.
- `misaligned_out`  out  1  one-cycle flag: current request is misaligned and was rejected.
- `ahb_haddr_out`  out  XLEN  HADDR, aligned to XLEN/8 bytes.
- `ahb_hwdata_out`  out  XLEN  HWDATA.
- `wr_mask_out`  out  XLEN/8  byte-lane write strobe for the current data phase.
- `ahb_hsize_out`  out  3  HSIZE = {1'b0, size}.
- `ahb_hwrite_out`  out  1  HWRITE.
- `ahb_htrans_out`  out  2  HTRANS: 00 IDLE, 10 NONSEQ.

## Operation
- **Lane offset.** `off = iadder_in[log2(XLEN/8)-1:0]`; `nbytes = 1 << size`.
- **Entry contents**, captured on enqueue:
  - `addr = iadder_in` with the low `log2(XLEN/8)` bits cleared;
  - `data = (rs2_in & low nbytes mask) << (8*off)`; lanes outside the store are 0;
  - `strb = ((1<<nbytes)-1) << off`;
  - `hsize = {1'b0, size}`.
- **Enqueue condition.** An entry is enqueued when all of the following hold: `mem_wr_req_in`=1, the access is aligned (`off % nbytes == 0`), and either `count<DEPTH` or the head retires in the same cycle.
- **Illegal size.** On XLEN=32, size 11 is treated as word.
- **Pointers.** `wptr` is the enqueue pointer. `aptr` is the entry in address phase. `dptr` is the entry in data phase and is always the FIFO head. All pointers wrap modulo DEPTH. `count` runs 0..DEPTH.
- **FSM states.**
  - IDLE: HTRANS=00. Goes to ADDR when an un-issued entry exists (`aptr != wptr`, or the queue is full).
  - ADDR: drives NONSEQ with `haddr`/`hsize` of `aptr`. On HREADY=1, `aptr++` and go to DATA.
  - DATA: drives `hwdata`/`wr_mask_out` of `dptr`. While HREADY=0, data, strobe and any overlapped address phase are held stable. On HREADY=1 the head retires (`dptr++`, `count--`). The next state is then chosen as follows:
    - DATA, when a further entry was presented as an overlapped address phase this cycle; `aptr++`. This gives back-to-back stores at 1 per cycle.
    - ADDR, when an un-issued entry remains that was not overlapped.
    - IDLE, otherwise.
- **Outputs outside the data phase.** `ahb_hwrite_out`=1 whenever HTRANS=NONSEQ, otherwise 0. `wr_mask_out`=0 outside DATA.
- **Status flags.**
  - `full_out` = (count==DEPTH). It is combinational from registered count.
  - `empty_out` = (count==0) && state==IDLE.
- **Misaligned request.** `misaligned_out` is combinational from the current inputs. The entry is not enqueued.
- **Reset** (any time, including mid-transfer):
  - all pointers and `count` = 0; FSM = IDLE;
  - HTRANS = 00; HADDR, HWDATA, `wr_mask_out`, HSIZE, HWRITE = 0;
  - `full_out`=0, `empty_out`=1, `misaligned_out`=0;
  - queued stores are discarded.

## Timing
- Enqueue takes effect on the rising edge where the request is accepted. The earliest NONSEQ appears the following cycle, so bus latency from request to address phase is 1 cycle.
- The data phase is the cycle after the address phase completes. Store completion latency is 2 cycles plus wait states.
- Sustained throughput with HREADY=1 is one store per cycle.
- `full_out` deasserts in the cycle after the retiring edge.
- Enqueue and retire on the same edge with count==DEPTH: the store is accepted and count stays DEPTH.
- Enqueue into an empty queue while IDLE is accepted; there is no bypass to the bus.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - misaligned stores are rejected and flagged on `misaligned_out`, as described in Operation.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - `misaligned_out` is tied to 0;
  - misaligned stores are enqueued with `off` forced down to the nearest multiple of `nbytes`, which is legacy behaviour;
  - `strb` and `data` are computed from the forced offset.

## Test plan
- XLEN=32, SB at 0x1003 with rs2=0x11223344, HREADY=1 -> NONSEQ with HADDR=0x1000, HSIZE=000; next cycle HWDATA=0x44000000, strobe=1000.
- SH at 0x2002 with rs2=0xAABBCCDD -> HWDATA=0xCCDD0000, strobe=1100. SW at 0x2002 -> `misaligned_out`=1, no transfer; with the macro off, HADDR=0x2000 and strobe=1111.
- XLEN=64, SD at 0x8 with rs2=0x0123456789ABCDEF -> HADDR=0x8, HSIZE=011, strobe=0xFF.
- DEPTH=4, HREADY=0, five consecutive SW requests -> `full_out`=1 after the 4th accepted store, the 5th is held by stall. Release HREADY -> the 4 stores retire in 4 consecutive cycles with HWDATA held stable during the waits.
- Full queue with retire and enqueue on the same edge -> count stays 4 and the new store appears in FIFO order.
- Assert `rst_in` mid-data-phase with 3 stores queued -> HTRANS=00 immediately, `empty_out`=1, no further transfers after release.
